pipe_reg_array: RTL and testbench

- Parametrised N-deep bank of inter-stage pipeline registers for the in-order RV32I core.
- Replaces the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers and their ad-hoc load, stall and flush logic.
- Owns per-register valid bits, hold/bubble generation from per-stage stall requests, and younger-stage flush.
- Keeps saturating stall, flush and retire performance counters.

---
 rtl/pipe_reg_array.sv | 164 ++++++++++++++++
 tb/tb_pipe_reg_array.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_array.sv
// rtl/pipe_reg_array.sv - inter-stage pipeline register bank with stall, flush and perf counters
//
// Purpose: N-deep bank of pipeline registers for the in-order RV32I core.
// Register r sits between stage r and stage r+1 (r=0 is IF/ID). Handles
// per-register valid bits, hold/bubble generation from stall requests,
// younger-stage flush, and saturating performance counters.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/data  fetch payload offered to register 0
//   in_ready       register 0 loads this cycle
//   stage_next     per-register next payload (slice 0 unused, in_data feeds reg 0)
//   stall_req      bit r: stage r+1 cannot consume register r
//   flush_req/idx  kill registers 0..flush_idx
//   stage_data     register payloads
//   stage_valid    register valid bits
//   stage_load     register r loads this cycle
//   retire_valid   last register is valid and consumed this cycle
//   stall_cycles, flush_count, retire_count   saturating counters

module pipe_reg_array #(
    parameter int NUM_STAGES    = 4,
    parameter int WIDTH         = 128,
    parameter int CNT_W         = 32,
    parameter bit CLEAR_ON_KILL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    input  logic [NUM_STAGES*WIDTH-1:0]   stage_next,
    input  logic [NUM_STAGES-1:0]         stall_req,
    input  logic                          flush_req,
    input  logic [$clog2(NUM_STAGES)-1:0] flush_idx,
    output logic [NUM_STAGES*WIDTH-1:0]   stage_data,
    output logic [NUM_STAGES-1:0]         stage_valid,
    output logic [NUM_STAGES-1:0]         stage_load,
    output logic                          retire_valid,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              flush_count,
    output logic [CNT_W-1:0]              retire_count
);

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]      data_q [NUM_STAGES];
    logic [WIDTH-1:0]      data_d [NUM_STAGES];
    logic [WIDTH-1:0]      data_src [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_src;
    logic [NUM_STAGES-1:0] kill, eff, hold, hold_prev;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;
    logic                  zap;
    logic                  unused_slice0;

    // Slice 0 of stage_next has no consumer; register 0 is fed by in_data.
    assign unused_slice0 = ^stage_next[WIDTH-1:0];

    // Kill mask, effective stalls and hold chain. A stall propagates down to
    // every older-facing register below it, so hold[r] is the OR of eff[r..top].
    always_comb begin
        kill = '0;
        eff  = '0;
        hold = '0;
        for (int r = 0; r < NUM_STAGES; r++) begin
            kill[r] = flush_req && (r <= int'(flush_idx));
            eff[r]  = stall_req[r] && valid_q[r] && !kill[r];
        end
        for (int r = 0; r < NUM_STAGES; r++) begin
            hold[r] = |(eff >> r);
        end
    end

    // Per-register load sources; register 0 takes the fetch interface and is
    // never starved by an upstream hold.
    always_comb begin
        valid_src    = {valid_q[NUM_STAGES-2:0], in_valid};
        hold_prev    = {hold[NUM_STAGES-2:0], 1'b0};
        data_src[0]  = in_data;
        for (int r = 1; r < NUM_STAGES; r++) begin
            data_src[r] = stage_next[r*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        valid_d = valid_q;
        zap     = 1'b0;
        for (int r = 0; r < NUM_STAGES; r++) begin
            data_d[r] = data_q[r];
            zap       = 1'b0;
            if (!hold[r]) begin
                data_d[r] = data_src[r];
                if (hold_prev[r]) begin
                    // Upstream is held while this register drains: bubble.
                    valid_d[r] = 1'b0;
                    zap        = 1'b1;
                end else begin
                    valid_d[r] = valid_src[r];
                    zap        = (r == 0) && !in_valid;
                end
            end
            if (kill[r]) begin
                valid_d[r] = 1'b0;
                zap        = 1'b1;
            end
            if (CLEAR_ON_KILL && zap) begin
                data_d[r] = '0;
            end
        end
    end

    assign stage_load   = ~hold;
    assign in_ready     = ~hold[0];
    assign retire_valid = valid_q[NUM_STAGES-1] && !hold[NUM_STAGES-1];

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (!in_ready && !flush_req && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_req && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (retire_valid && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
            for (int r = 0; r < NUM_STAGES; r++) begin
                data_q[r] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            for (int r = 0; r < NUM_STAGES; r++) begin
                data_q[r] <= data_d[r];
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int r = 0; r < NUM_STAGES; r++) begin
            stage_data[r*WIDTH +: WIDTH] = data_q[r];
        end
    end

    assign stage_valid  = valid_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign retire_count = retire_cnt_q;

endmodule

// File: tb/tb_pipe_reg_array.sv
// tb/tb_pipe_reg_array.sv - directed self-checking bench for pipe_reg_array

module tb_pipe_reg_array;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready, s_in_ready;
    logic [N*W-1:0] stage_next;
    logic [N-1:0]   stall_req;
    logic           flush_req;
    logic [1:0]     flush_idx;
    logic [N*W-1:0] stage_data, s_stage_data;
    logic [N-1:0]   stage_valid, s_stage_valid;
    logic [N-1:0]   stage_load, s_stage_load;
    logic           retire_valid, s_retire_valid;
    logic [31:0]    stall_cycles, flush_count, retire_count;
    logic [1:0]     s_stall_cycles, s_flush_count, s_retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_reg_array #(.NUM_STAGES(N), .WIDTH(W), .CNT_W(32), .CLEAR_ON_KILL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stage_next(stage_next), .stall_req(stall_req), .flush_req(flush_req),
        .flush_idx(flush_idx), .stage_data(stage_data), .stage_valid(stage_valid),
        .stage_load(stage_load), .retire_valid(retire_valid), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .retire_count(retire_count)
    );

    // Narrow-counter copy driven identically, used to observe saturation.
    pipe_reg_array #(.NUM_STAGES(N), .WIDTH(W), .CNT_W(2), .CLEAR_ON_KILL(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .stage_next(stage_next), .stall_req(stall_req), .flush_req(flush_req),
        .flush_idx(flush_idx), .stage_data(s_stage_data), .stage_valid(s_stage_valid),
        .stage_load(s_stage_load), .retire_valid(s_retire_valid), .stall_cycles(s_stall_cycles),
        .flush_count(s_flush_count), .retire_count(s_retire_count)
    );

    // Each stage adds one to the payload it passes on.
    always_comb begin
        stage_next = '0;
        for (int r = 1; r < N; r++) begin
            stage_next[r*W +: W] = stage_data[(r-1)*W +: W] + 32'd1;
        end
    end

    function automatic logic [W-1:0] sd(input int r);
        return stage_data[r*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        stall_req = '0;
        flush_req = 1'b0;
        flush_idx = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Four payloads base+16k, k=1..4; afterwards every register is valid:
    // reg0=base+64, reg1=base+49, reg2=base+34, reg3=base+19.
    task automatic fill(input logic [W-1:0] base);
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_data  = base + W'(k * 16);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 64'(stage_valid), 64'h0);
        chk("rst_data", 64'(|stage_data), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_counters", 64'({stall_cycles, flush_count} | 64'(retire_count)), 64'h0);

        // Stream A1..A6 with no stalls.
        for (int e = 1; e <= 10; e++) begin
            in_valid = (e <= 6);
            in_data  = (e <= 6) ? 32'hA000 + W'(e * 16) : '0;
            tick();
            if (e == 4) begin
                chk("stream_reg3_data", 64'(sd(3)), 64'hA013);
                chk("stream_retire_valid", 64'(retire_valid), 64'h1);
            end
        end
        chk("stream_retire_count", 64'(retire_count), 64'd6);
        chk("stream_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("stream_drained", 64'(stage_valid), 64'h0);
        chk("sat_retire_count", 64'(s_retire_count), 64'h3);

        // stall_req[2] for three cycles with everything valid.
        do_reset();
        fill(32'hB000);
        stall_req = 4'b0100;
        in_valid  = 1'b1;
        in_data   = 32'hB050;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'h0);
        chk("stall_load", 64'(stage_load), 64'h8);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_valid", 64'(stage_valid), 64'h7);
            chk("stall_reg2_held", 64'(sd(2)), 64'hB022);
            chk("stall_reg3_bubble", 64'(sd(3)), 64'h0);
        end
        stall_req = '0;
        tick();
        chk("resume_valid", 64'(stage_valid), 64'hF);
        chk("resume_reg3", 64'(sd(3)), 64'hB023);
        chk("resume_reg0", 64'(sd(0)), 64'hB050);
        chk("resume_stall_cycles", 64'(stall_cycles), 64'd3);
        chk("resume_retire_count", 64'(retire_count), 64'd1);

        // Flush registers 0..1 while stage 1 requests a stall.
        do_reset();
        fill(32'hC000);
        in_valid  = 1'b1;
        in_data   = 32'hC050;
        flush_req = 1'b1;
        flush_idx = 2'd1;
        stall_req = 4'b0001;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'h1);
        tick();
        idle_inputs();
        chk("flush_valid", 64'(stage_valid), 64'hC);
        chk("flush_reg0", 64'(sd(0)), 64'h0);
        chk("flush_reg1", 64'(sd(1)), 64'h0);
        chk("flush_reg2", 64'(sd(2)), 64'hC032);
        chk("flush_reg3", 64'(sd(3)), 64'hC023);
        chk("flush_count1", 64'(flush_count), 64'd1);
        flush_req = 1'b1;
        flush_idx = 2'd3;
        tick();
        idle_inputs();
        chk("flush_all_valid", 64'(stage_valid), 64'h0);
        chk("flush_count2", 64'(flush_count), 64'd2);

        // Simultaneous stalls at 1 and 3: everything holds, no bubble.
        do_reset();
        fill(32'hD000);
        stall_req = 4'b1010;
        in_valid  = 1'b1;
        in_data   = 32'hD050;
        #1;
        chk("multi_load", 64'(stage_load), 64'h0);
        chk("multi_retire_valid", 64'(retire_valid), 64'h0);
        tick();
        chk("multi_valid", 64'(stage_valid), 64'hF);
        chk("multi_reg0", 64'(sd(0)), 64'hD040);
        chk("multi_reg1", 64'(sd(1)), 64'hD031);
        chk("multi_reg3", 64'(sd(3)), 64'hD013);
        idle_inputs();

        // Stall request on an invalid register is ignored.
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'hE010;
        tick();
        in_data   = 32'hE020;
        stall_req = 4'b0100;
        #1;
        chk("inv_stall_ready", 64'(in_ready), 64'h1);
        chk("inv_stall_load", 64'(stage_load), 64'hF);
        tick();
        idle_inputs();
        chk("inv_stall_valid", 64'(stage_valid), 64'h3);
        chk("inv_stall_reg1", 64'(sd(1)), 64'hE011);
        chk("inv_stall_cycles", 64'(stall_cycles), 64'd0);

        // Reset mid-stream with a stall active.
        fill(32'hF000);
        stall_req = 4'b0100;
        in_valid  = 1'b1;
        in_data   = 32'hF050;
        tick();
        chk("pre_rst_stall_cycles", 64'(stall_cycles), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(stage_valid), 64'h0);
        chk("mid_rst_data", 64'(|stage_data), 64'h0);
        chk("mid_rst_counters", 64'({stall_cycles, flush_count} | 64'(retire_count)), 64'h0);
        chk("mid_rst_sat", 64'(s_retire_count), 64'h0);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
